// File: rtl/lts_pkg.sv
// Shared constants, state encoding and sample payload for the LTS pair buffer.
package lts_pkg;

   localparam int unsigned N_FFT    = 64;
   localparam int unsigned BIN_W    = 6;
   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned NULL_LO  = 27;
   localparam int unsigned NULL_HI  = 37;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      PAIR    = 2'd2
   } state_t;

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] i;
      logic signed [SAMPLE_W-1:0] q;
   } sample_t;

   // DC bin and the guard band carry no training energy.
   function automatic logic is_null_bin(input logic [BIN_W-1:0] bin);
      return (bin == '0) || ((bin >= BIN_W'(NULL_LO)) && (bin <= BIN_W'(NULL_HI)));
   endfunction

endpackage

// File: rtl/lts_sign_rom.sv
// 802.11a long training sequence sign per FFT bin: 1 where L[k] = -1, 0 elsewhere.
module lts_sign_rom
   import lts_pkg::*;
(
   input  logic [BIN_W-1:0] bin,
   output logic             sign_c
);

   // Bins 1..26 map to L[1..26], bins 38..63 map to L[-26..-1].
   always_comb begin
      sign_c = 1'b0;
      case (bin)
         6'd2,  6'd3,  6'd6,  6'd8,  6'd10, 6'd11, 6'd12,
         6'd13, 6'd14, 6'd17, 6'd18, 6'd20, 6'd22,
         6'd40, 6'd41, 6'd44, 6'd46, 6'd53, 6'd54, 6'd57, 6'd59: sign_c = 1'b1;
         default: sign_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/lts_pair_buffer.sv
// Stores LTS symbol 1 and pairs each bin with the live LTS symbol 2 sample.
// Define LTS_NULL_SKIP_EN to suppress pair_strobe on null bins (52 pairs per run).
module lts_pair_buffer
   import lts_pkg::*;
(
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       start,
   input  logic signed [SAMPLE_W-1:0] sample_in_i,
   input  logic signed [SAMPLE_W-1:0] sample_in_q,
   input  logic                       sample_in_strobe,
   output logic signed [SAMPLE_W-1:0] a_i,
   output logic signed [SAMPLE_W-1:0] a_q,
   output logic signed [SAMPLE_W-1:0] b_i,
   output logic signed [SAMPLE_W-1:0] b_q,
   output logic                       sign,
   output logic [BIN_W-1:0]           pair_index,
   output logic                       pair_strobe,
   output logic                       done
);

   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_FFT - 1);

   state_t           state, state_nx;
   logic [BIN_W-1:0] cnt, cnt_nx;
   logic [BIN_W-1:0] wr_addr_c;
   logic             wr_en_c, rd_en_c, last_c, pair_c, sign_c;
   sample_t          mem [N_FFT];

   lts_sign_rom u_sign_rom (
      .bin    (cnt),
      .sign_c (sign_c)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (enable) begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // start wins in every state; a strobe in the start cycle lands in bin 0.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      wr_addr_c = cnt;
      wr_en_c   = 1'b0;
      rd_en_c   = 1'b0;
      last_c    = 1'b0;
      if (start) begin
         state_nx  = CAPTURE;
         wr_addr_c = '0;
         wr_en_c   = sample_in_strobe;
         cnt_nx    = sample_in_strobe ? BIN_W'(1) : '0;
      end else begin
         case (state)
            CAPTURE: begin
               if (sample_in_strobe) begin
                  wr_en_c = 1'b1;
                  cnt_nx  = cnt + BIN_W'(1);
                  if (cnt == LAST_BIN) state_nx = PAIR;
               end
            end
            PAIR: begin
               if (sample_in_strobe) begin
                  rd_en_c = 1'b1;
                  cnt_nx  = cnt + BIN_W'(1);
                  if (cnt == LAST_BIN) begin
                     state_nx = IDLE;
                     last_c   = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef LTS_NULL_SKIP_EN
   assign pair_c = rd_en_c && !is_null_bin(cnt);
`else
   assign pair_c = rd_en_c;
`endif

   // Write port of the LTS1 buffer.
   always_ff @(posedge clock) begin
      if (enable && wr_en_c) mem[wr_addr_c] <= {sample_in_i, sample_in_q};
   end

   // Registered read port doubles as the a_* output register.
   always_ff @(posedge clock) begin
      if (reset) begin
         a_i <= '0;
         a_q <= '0;
      end else if (enable && pair_c) begin
         {a_i, a_q} <= mem[cnt];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         b_i         <= '0;
         b_q         <= '0;
         sign        <= 1'b0;
         pair_index  <= '0;
         pair_strobe <= 1'b0;
         done        <= 1'b0;
      end else if (enable) begin
         pair_strobe <= pair_c;
         done        <= last_c;
         if (pair_c) begin
            b_i        <= sample_in_i;
            b_q        <= sample_in_q;
            sign       <= sign_c;
            pair_index <= cnt;
         end
      end
   end

endmodule

// File: tb/tb_lts_pair_buffer.sv
// Self-checking bench for lts_pair_buffer: behavioural model feeds a scoreboard queue.
module tb_lts_pair_buffer;

   logic               clock, reset, enable, start, sample_in_strobe;
   logic signed [15:0] sample_in_i, sample_in_q;
   logic signed [15:0] a_i, a_q, b_i, b_q;
   logic               sign, pair_strobe, done;
   logic [5:0]         pair_index;

   lts_pair_buffer dut (
      .clock            (clock),
      .reset            (reset),
      .enable           (enable),
      .start            (start),
      .sample_in_i      (sample_in_i),
      .sample_in_q      (sample_in_q),
      .sample_in_strobe (sample_in_strobe),
      .a_i              (a_i),
      .a_q              (a_q),
      .b_i              (b_i),
      .b_q              (b_q),
      .sign             (sign),
      .pair_index       (pair_index),
      .pair_strobe      (pair_strobe),
      .done             (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

`ifdef LTS_NULL_SKIP_EN
   localparam int EXP_PAIRS = 52;
`else
   localparam int EXP_PAIRS = 64;
`endif

   typedef struct packed {
      logic [5:0]         idx;
      logic signed [15:0] ai, aq, bi, bq;
      logic               sg;
      logic               last;
   } exp_t;

   typedef struct {
      int   bin;
      logic exp_sign;
   } sign_vec_t;

   exp_t               exp_q[$];
   exp_t               last_e, mon_e;
   logic signed [15:0] model_i [64];
   logic signed [15:0] model_q [64];
   logic               seen_valid [64];
   logic               seen_sign  [64];
   sign_vec_t          sv [8];
   int                 ph, mcnt;
   int                 n_checks, n_err, n_pairs, n_done;
   logic               rand_en, exp_pair_now;
   logic               mon_en, mon_rst, mon_ep;
   int                 l_seq [53];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   function automatic logic skip(input int k);
`ifdef LTS_NULL_SKIP_EN
      return (k == 0) || (k >= 27 && k <= 37);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic sign_model(input int k);
      if (k >= 1 && k <= 26) return l_seq[k + 26] == -1;
      if (k >= 38 && k <= 63) return l_seq[k - 64 + 26] == -1;
      return 1'b0;
   endfunction

   // Drive one control/sample cycle and update the model; held until an enabled edge.
   task automatic send(input logic st, input logic stb, input int i, input int q);
      exp_t e;
      @(negedge clock);
      start            = st;
      sample_in_strobe = stb;
      sample_in_i      = 16'(i);
      sample_in_q      = 16'(q);
      exp_pair_now     = 1'b0;
      if (st) begin ph = 1; mcnt = 0; end
      if (stb) begin
         if (ph == 1) begin
            model_i[mcnt] = 16'(i);
            model_q[mcnt] = 16'(q);
            mcnt++;
            if (mcnt == 64) begin ph = 2; mcnt = 0; end
         end else if (ph == 2) begin
            if (!skip(mcnt)) begin
               e.idx  = 6'(mcnt);
               e.ai   = model_i[mcnt];
               e.aq   = model_q[mcnt];
               e.bi   = 16'(i);
               e.bq   = 16'(q);
               e.sg   = sign_model(mcnt);
               e.last = (mcnt == 63);
               exp_q.push_back(e);
               exp_pair_now = 1'b1;
            end
            mcnt++;
            if (mcnt == 64) begin ph = 0; mcnt = 0; end
         end
      end
      enable = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      while (!enable) begin
         @(negedge clock);
         enable = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         start            = 1'b0;
         sample_in_strobe = 1'b0;
         exp_pair_now     = 1'b0;
         enable           = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_a_i"}, a_i, 0);
      chk({tag, "_a_q"}, a_q, 0);
      chk({tag, "_b_i"}, b_i, 0);
      chk({tag, "_b_q"}, b_q, 0);
      chk({tag, "_sign"}, sign, 0);
      chk({tag, "_pair_index"}, pair_index, 0);
      chk({tag, "_pair_strobe"}, pair_strobe, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   // Monitor: every enabled edge, pair_strobe must match the strobe accepted at that edge.
   always @(posedge clock) begin
      mon_en  = enable;
      mon_rst = reset;
      mon_ep  = exp_pair_now && enable && !reset;
      #1;
      if (!mon_rst && mon_en) begin
         chk("pair_strobe_timing", pair_strobe, mon_ep);
         if (pair_strobe) begin
            n_pairs++;
            seen_valid[pair_index] = 1'b1;
            seen_sign[pair_index]  = sign;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_pair: bin %0d with empty scoreboard", pair_index);
            end else begin
               mon_e = exp_q.pop_front();
               chk("pair_index", pair_index, mon_e.idx);
               chk("a_i", a_i, mon_e.ai);
               chk("a_q", a_q, mon_e.aq);
               chk("b_i", b_i, mon_e.bi);
               chk("b_q", b_q, mon_e.bq);
               chk("sign", sign, mon_e.sg);
               chk("done", done, mon_e.last);
               last_e = mon_e;
            end
         end else begin
            chk("done_without_pair", done, 0);
            chk("hold_a", {a_i, a_q}, {last_e.ai, last_e.aq});
            chk("hold_b", {b_i, b_q}, {last_e.bi, last_e.bq});
         end
         if (done) n_done++;
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int p0, d0, exp_cnt;
      l_seq = '{1, 1, -1, -1, 1, 1, -1, 1, -1, 1, 1, 1, 1, 1, 1, -1, -1, 1, 1, -1, 1, -1, 1, 1, 1, 1,
                0,
                1, -1, -1, 1, 1, -1, 1, -1, 1, -1, -1, -1, -1, -1, 1, 1, -1, -1, 1, -1, 1, -1, 1, 1, 1, 1};
      sv[0] = '{1, 1'b0};  sv[1] = '{3, 1'b1};  sv[2] = '{32, 1'b0}; sv[3] = '{38, 1'b0};
      sv[4] = '{40, 1'b1}; sv[5] = '{2, 1'b1};  sv[6] = '{26, 1'b0}; sv[7] = '{63, 1'b0};
      n_checks = 0; n_err = 0; n_pairs = 0; n_done = 0;
      ph = 0; mcnt = 0; rand_en = 1'b0; exp_pair_now = 1'b0; last_e = '0;
      reset = 1'b1; enable = 1'b1; start = 1'b0; sample_in_strobe = 1'b0;
      sample_in_i = '0; sample_in_q = '0;
      foreach (seen_valid[k]) begin seen_valid[k] = 1'b0; seen_sign[k] = 1'b0; end

      repeat (3) @(negedge clock);
      chk_zero("reset");
      reset = 1'b0;

      // Basic run; start and the first LTS1 strobe coincide.
      p0 = n_pairs; d0 = n_done;
      for (int k = 0; k < 64; k++) send(k == 0, 1'b1, k, -k);
      for (int k = 0; k < 64; k++) send(1'b0, 1'b1, 100 + k, 0);
      idle(3);
      chk("run1_pairs", n_pairs - p0, EXP_PAIRS);
      chk("run1_done", n_done - d0, 1);
      chk("run1_last_index", pair_index, 63);

      for (int v = 0; v < 8; v++) begin
         if (skip(sv[v].bin)) chk($sformatf("null_bin_%0d_skipped", sv[v].bin), seen_valid[sv[v].bin], 0);
         else begin
            chk($sformatf("bin_%0d_seen", sv[v].bin), seen_valid[sv[v].bin], 1);
            chk($sformatf("bin_%0d_sign", sv[v].bin), seen_sign[sv[v].bin], sv[v].exp_sign);
         end
      end

      // Gapped LTS2 strobes with enable toggling.
      rand_en = 1'b1;
      p0 = n_pairs; d0 = n_done;
      for (int k = 0; k < 64; k++) send(k == 0, 1'b1, -37 * k, 11 * k + 5);
      for (int k = 0; k < 64; k++) begin
         send(1'b0, 1'b1, 3 * k - 50, -k);
         idle(1);
      end
      rand_en = 1'b0;
      idle(3);
      chk("run2_pairs", n_pairs - p0, EXP_PAIRS);
      chk("run2_done", n_done - d0, 1);

      // Abort at LTS2 bin 10, then a fresh full run.
      p0 = n_pairs; d0 = n_done;
      for (int k = 0; k < 64; k++) send(k == 0, 1'b1, 500 + k, 600 + k);
      for (int k = 0; k < 10; k++) send(1'b0, 1'b1, 700 + k, 800 + k);
      send(1'b1, 1'b0, 0, 0);
      for (int k = 0; k < 64; k++) send(1'b0, 1'b1, -1000 - k, 2000 + k);
      for (int k = 0; k < 64; k++) send(1'b0, 1'b1, 3000 + k, -3000 - k);
      idle(3);
      exp_cnt = EXP_PAIRS;
      for (int k = 0; k < 10; k++) if (!skip(k)) exp_cnt++;
      chk("abort_pairs", n_pairs - p0, exp_cnt);
      chk("abort_done", n_done - d0, 1);

      // Reset at PAIR bin 20 overrides a low enable; later strobes are ignored.
      for (int k = 0; k < 64; k++) send(k == 0, 1'b1, 40 + k, 50 + k);
      for (int k = 0; k < 20; k++) send(1'b0, 1'b1, 60 + k, 70 + k);
      @(negedge clock);
      reset = 1'b1; enable = 1'b0; start = 1'b0; sample_in_strobe = 1'b0; exp_pair_now = 1'b0;
      ph = 0; mcnt = 0; last_e = '0;
      @(posedge clock);
      #1;
      chk_zero("midrun_reset");
      @(negedge clock);
      reset = 1'b0; enable = 1'b1;
      p0 = n_pairs; d0 = n_done;
      for (int k = 0; k < 10; k++) send(1'b0, 1'b1, 90 + k, 91 + k);
      idle(3);
      chk("post_reset_pairs", n_pairs - p0, 0);
      chk("post_reset_done", n_done - d0, 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
